// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StMemCmd,
    StMemRsp,
    StIfCmd,
    StIfRsp,
    StDone
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-outstanding bus port, stalling the
// pipeline until every access requested in the current pipeline cycle has completed.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ARB_ADDR_W,
  parameter int unsigned DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                axi_stall
);

  arb_state_t state_q, state_d;

  logic                hold_if_q;
  logic                hold_mem_q;
  logic                hold_we_q;
  logic [DATA_W/8-1:0] hold_wstrb_q;
  logic [ADDR_W-1:0]   hold_iaddr_q;
  logic [ADDR_W-1:0]   hold_maddr_q;
  logic [DATA_W-1:0]   hold_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;
  logic                any_req;

  assign any_req   = if_req | mem_req;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

  always_comb begin
    state_d   = state_q;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    axi_stall = 1'b1;
    unique case (state_q)
      StIdle: begin
        axi_stall = any_req;
        // Data access always goes first within a pipeline cycle.
        if (mem_req) begin
          state_d = StMemCmd;
        end else if (if_req) begin
          state_d = StIfCmd;
        end
      end
      StMemCmd: begin
        bus_valid = 1'b1;
        bus_we    = hold_we_q;
        bus_wstrb = hold_wstrb_q;
        bus_addr  = hold_maddr_q;
        bus_wdata = hold_wdata_q;
        if (bus_ready) state_d = StMemRsp;
      end
      StMemRsp: begin
        if (bus_rvalid) state_d = hold_if_q ? StIfCmd : StDone;
      end
      StIfCmd: begin
        bus_valid = 1'b1;
        bus_addr  = hold_iaddr_q;
        if (bus_ready) state_d = StIfRsp;
      end
      StIfRsp: begin
        if (bus_rvalid) state_d = StDone;
      end
      StDone: begin
        axi_stall = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        axi_stall = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hold_if_q    <= 1'b0;
      hold_mem_q   <= 1'b0;
      hold_we_q    <= 1'b0;
      hold_wstrb_q <= '0;
      hold_iaddr_q <= '0;
      hold_maddr_q <= '0;
      hold_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && any_req) begin
        hold_if_q    <= if_req;
        hold_mem_q   <= mem_req;
        hold_we_q    <= mem_we;
        hold_wstrb_q <= mem_wstrb;
        hold_iaddr_q <= if_addr;
        hold_maddr_q <= mem_addr;
        hold_wdata_q <= mem_wdata;
      end
      // A write acknowledge carries no load data.
      if (state_q == StMemRsp && bus_rvalid && hold_mem_q && !hold_we_q) begin
        mem_rdata_q <= bus_rdata;
      end
      if (state_q == StIfRsp && bus_rvalid) begin
        if_rdata_q <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, randomized transactions against a
// transaction-level model, plus stray-response and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        axi_stall;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_wstrb (bus_wstrb),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata),
    .axi_stall (axi_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic        m_req;
    logic        m_we;
    logic [3:0]  strb;
    logic [31:0] iaddr;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] rd_m;
    logic [31:0] rd_i;
    int          rw_m;  // cycles bus_ready held low
    int          sw_m;  // extra response latency in cycles
    int          rw_i;
    int          sw_i;
  } txn_t;

  int vectors = 0;
  int miscompares = 0;

  // Model of the latched read data, updated at transaction granularity.
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_mem_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input txn_t t);
    logic        is_mem [2];
    int          rw     [2];
    int          sw     [2];
    logic [31:0] rd     [2];
    int n = 0;
    int k = 0;
    int wcnt = 0;
    int rcnt = 0;
    int stalls = 0;
    int exp_stalls = 1;
    logic pending = 1'b0;
    logic done = 1'b0;
    if (t.m_req) begin
      is_mem[n] = 1'b1; rw[n] = t.rw_m; sw[n] = t.sw_m; rd[n] = t.rd_m; n++;
      exp_stalls += 2 + t.rw_m + t.sw_m;
    end
    if (t.i_req) begin
      is_mem[n] = 1'b0; rw[n] = t.rw_i; sw[n] = t.sw_i; rd[n] = t.rd_i; n++;
      exp_stalls += 2 + t.rw_i + t.sw_i;
    end
    @(negedge clk);
    if_req    = t.i_req;
    if_addr   = t.iaddr;
    mem_req   = t.m_req;
    mem_we    = t.m_we;
    mem_wstrb = t.strb;
    mem_addr  = t.maddr;
    mem_wdata = t.wdata;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = $urandom;
      #1;
      if (cyc == 0) check("stall_on_request", 32'(axi_stall), 32'd1);
      if (!axi_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (bus_valid) begin
          check("cmd_in_range", 32'(k < n), 32'd1);
          if (k < n) begin
            if (is_mem[k]) begin
              check("mem_cmd_we", 32'(bus_we), 32'(t.m_we));
              check("mem_cmd_strb", 32'(bus_wstrb), 32'(t.strb));
              check("mem_cmd_addr", bus_addr, t.maddr);
              check("mem_cmd_wdata", bus_wdata, t.wdata);
            end else begin
              check("if_cmd_we", 32'(bus_we), 32'd0);
              check("if_cmd_strb", 32'(bus_wstrb), 32'd0);
              check("if_cmd_addr", bus_addr, t.iaddr);
            end
            if (wcnt == rw[k]) begin
              bus_ready = 1'b1;
              pending   = 1'b1;
              rcnt      = sw[k];
              wcnt      = 0;
            end else begin
              wcnt++;
            end
          end
        end else if (pending) begin
          if (rcnt == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd[k];
            pending    = 1'b0;
            k++;
          end else begin
            rcnt--;
          end
        end
      end
    end
    if (t.m_req && !t.m_we) exp_mem_rdata = t.rd_m;
    if (t.i_req) exp_if_rdata = t.rd_i;
    check("done_reached", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("cmd_count", 32'(k), 32'(n));
    check("done_bus_valid", 32'(bus_valid), 32'd0);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("mem_rdata", mem_rdata, exp_mem_rdata);
    if_req  = 1'b0;
    mem_req = 1'b0;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.i_req = 1'($urandom);
    t.m_req = 1'($urandom);
    if (!t.i_req && !t.m_req) t.i_req = 1'b1;
    t.m_we  = 1'($urandom);
    t.strb  = 4'($urandom);
    t.iaddr = $urandom;
    t.maddr = $urandom;
    t.wdata = $urandom;
    t.rd_m  = $urandom;
    t.rd_i  = $urandom;
    t.rw_m  = int'($urandom_range(0, 3));
    t.sw_m  = int'($urandom_range(0, 3));
    t.rw_i  = int'($urandom_range(0, 3));
    t.sw_i  = int'($urandom_range(0, 3));
    return t;
  endfunction

  txn_t table_v [5];

  initial begin
    table_v[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h00A00093,
                   0, 0, 0, 0};
    table_v[1] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h104, 32'h8000, 32'h0, 32'h1234, 32'h5678,
                   0, 0, 0, 0};
    table_v[2] = '{1'b0, 1'b1, 1'b1, 4'b0011, 32'h0, 32'h8004, 32'hDEADBEEF, 32'hCAFE0000,
                   32'h0, 2, 0, 0, 0};
    table_v[3] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h108, 32'h0, 32'h0, 32'h0, 32'h13579BDF,
                   0, 0, 0, 3};
    table_v[4] = '{1'b1, 1'b1, 1'b0, 4'h5, 32'h10C, 32'h9000, 32'h11, 32'hA5A5A5A5,
                   32'h5A5A5A5A, 1, 2, 2, 1};

    rst        = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_wstrb  = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_bus_valid", 32'(bus_valid), 32'd0);
    check("reset_bus_we", 32'(bus_we), 32'd0);
    check("reset_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("reset_bus_addr", bus_addr, 32'd0);
    check("reset_bus_wdata", bus_wdata, 32'd0);
    check("reset_axi_stall", 32'(axi_stall), 32'd0);
    check("reset_if_rdata", if_rdata, 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);

    for (int i = 0; i < 5; i++) run_txn(table_v[i]);

    // Stray response while idle must not disturb latched data.
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBADBAD00;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("stray_if_rdata", if_rdata, exp_if_rdata);
    check("stray_mem_rdata", mem_rdata, exp_mem_rdata);
    check("stray_stall", 32'(axi_stall), 32'd0);

    // Ten fetches with a new request in the cycle right after each DONE.
    for (int i = 0; i < 10; i++) begin
      txn_t t;
      t = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h200 + 32'(4 * i), 32'h0, 32'h0, 32'h0, $urandom,
            0, 0, 0, 0};
      run_txn(t);
    end

    for (int i = 0; i < 40; i++) run_txn(rand_txn());

    // Make sure a load is the last thing latched before the reset sequence.
    run_txn('{1'b1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h400, 32'h0, 32'h600DF00D, 32'hFEEDFACE,
              0, 0, 0, 0});

    // Reset while waiting in MEM_RSP.
    @(negedge clk);
    mem_req  = 1'b1;
    mem_we   = 1'b0;
    mem_addr = 32'hA000;
    #1;
    check("rst_seq_idle_stall", 32'(axi_stall), 32'd1);
    @(negedge clk);
    #1;
    check("rst_seq_cmd_valid", 32'(bus_valid), 32'd1);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    check("rst_seq_rsp_valid", 32'(bus_valid), 32'd0);
    check("rst_seq_rsp_stall", 32'(axi_stall), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    mem_req = 1'b0;
    #1;
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
    check("post_rst_bus_valid", 32'(bus_valid), 32'd0);
    check("post_rst_stall", 32'(axi_stall), 32'd0);
    check("post_rst_if_rdata", if_rdata, exp_if_rdata);
    check("post_rst_mem_rdata", mem_rdata, exp_mem_rdata);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h77777777;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    check("late_rsp_if_rdata", if_rdata, exp_if_rdata);
    check("late_rsp_mem_rdata", mem_rdata, exp_mem_rdata);
    check("late_rsp_bus_valid", 32'(bus_valid), 32'd0);

    run_txn(rand_txn());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
